// File: rtl/mips_pkg.sv
// mips_pkg: opcode, funct and PC-source encodings shared by the multicycle MIPS datapath and control
package mips_pkg;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J = 6'b000010;
    localparam logic [5:0] OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ORI = 6'b001101;
    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [1:0] PCSRC_ALU = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP = 2'b10;
    localparam logic [1:0] PCSRC_HOLD = 2'b11;

    function automatic logic [31:0] sext16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction
endpackage

// File: rtl/mips_fetch_unit_en_reg.sv
// en_reg: load-enabled register with asynchronous active-low reset to a parameterised value
module en_reg #(
    parameter int W = 32,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clock,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    always_ff @(posedge clock or negedge rst)
        if (!rst) q <= RST_VAL;
        else if (en) q <= d;
endmodule

// File: rtl/mips_fetch_unit.sv
// mips_fetch_unit: PC, IR and ALUOut registers driven by the multicycle control strobes,
// plus field decode of the latched instruction.
module mips_fetch_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int IMEM_AW = 8
) (
    input  logic               clock,
    input  logic               rst,
    input  logic               PC_write,
    input  logic               Branch,
    input  logic               IR_write,
    input  logic               ALU_reg_write,
    input  logic [1:0]         Pc_src_mux,
    input  logic [31:0]        alu_result,
    input  logic               alu_zero,
    input  logic [31:0]        imem_rdata,
    output logic [IMEM_AW-1:0] imem_addr,
    output logic [31:0]        pc,
    output logic [31:0]        alu_out,
    output logic [5:0]         op,
    output logic [5:0]         Funct,
    output logic [4:0]         rs,
    output logic [4:0]         rt,
    output logic [4:0]         rd,
    output logic [31:0]        imm_sext,
    output logic [31:0]        imm_br,
    output logic               instr_valid,
    output logic [15:0]        retired
);
    logic [31:0] ir, next_pc;
    logic pc_load;

    assign pc_load = PC_write | (Branch & alu_zero);
    // Jump target comes from the latched IR, never from the word currently on imem_rdata
    assign next_pc = (Pc_src_mux == PCSRC_ALU) ? alu_result :
                     (Pc_src_mux == PCSRC_ALUOUT) ? alu_out :
                     (Pc_src_mux == PCSRC_JUMP) ? {pc[31:28], ir[25:0], 2'b00} : pc;

    en_reg #(.W(32), .RST_VAL(RESET_PC)) u_pc (
        .clock(clock), .rst(rst), .en(pc_load), .d(next_pc), .q(pc)
    );
    en_reg #(.W(32), .RST_VAL(32'h0)) u_ir (
        .clock(clock), .rst(rst), .en(IR_write), .d(imem_rdata), .q(ir)
    );
    en_reg #(.W(32), .RST_VAL(32'h0)) u_alu_out (
        .clock(clock), .rst(rst), .en(ALU_reg_write), .d(alu_result), .q(alu_out)
    );

    always_ff @(posedge clock or negedge rst)
        if (!rst) begin
            instr_valid <= 1'b0;
            retired <= '0;
        end else begin
            if (IR_write) instr_valid <= 1'b1;
            if (pc_load) retired <= retired + 16'd1;
        end

    assign imem_addr = pc[IMEM_AW+1:2];
    assign op = ir[31:26];
    assign rs = ir[25:21];
    assign rt = ir[20:16];
    assign rd = ir[15:11];
    assign Funct = ir[5:0];
    assign imm_sext = sext16(ir[15:0]);
    assign imm_br = {imm_sext[29:0], 2'b00};
endmodule

// File: doc/mips_fetch_unit.md
# mips_fetch_unit

Datapath-side responder to the multicycle MIPS control FSM. Holds the program counter, instruction register and ALU-result register, and applies the FSM's `PC_write`, `IR_write`, `Pc_src_mux`, `Branch` and `ALU_reg_write` strobes. It also decodes the latched instruction into the `op`/`Funct` fields that the FSM consumes. It sits between instruction memory, the ALU and the control FSM.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value after reset.
- `IMEM_AW`, default 8: instruction-memory word-address width.
- `clock` in 1: single clock; all state updates on its rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `PC_write` in 1: unconditional PC load enable.
- `Branch` in 1: conditional PC load; loads only when `alu_zero`=1.
- `IR_write` in 1: instruction register load enable.
- `ALU_reg_write` in 1: ALUOut register load enable.
- `Pc_src_mux` in 2: PC source select: 00 alu_result, 01 ALUOut, 10 jump target, 11 hold.
- `alu_result` in 32: combinational ALU output.
- `alu_zero` in 1: ALU zero flag.
- `imem_rdata` in 32: instruction word at `imem_addr`, combinational read.
- `imem_addr` out IMEM_AW: `pc[IMEM_AW+1:2]`.
- `pc` out 32: current PC.
- `alu_out` out 32: ALUOut register.
- `op` out 6: `IR[31:26]`.
- `Funct` out 6: `IR[5:0]`.
- `rs`, `rt`, `rd` out 5 each: `IR[25:21]`, `IR[20:16]`, `IR[15:11]`.
- `imm_sext` out 32: sign-extended `IR[15:0]`.
- `imm_br` out 32: `imm_sext << 2`.
- `instr_valid` out 1: IR holds a fetched word since reset.
- `retired` out 16: count of PC loads since reset; wraps.

## Operation
- Reset (async, `rst`=0): `pc`=RESET_PC, IR=0 (so `op`=0, `Funct`=0), `alu_out`=0, `instr_valid`=0, `retired`=0. Decode outputs follow IR=0.
- IR: when `IR_write`=1, `IR <= imem_rdata` and `instr_valid <= 1`. Otherwise IR holds.
- ALUOut: when `ALU_reg_write`=1, `alu_out <= alu_result`. Otherwise it holds. The FSM drops this strobe during BEQ compare so ALUOut keeps the branch target.
- PC next value by `Pc_src_mux`:
  - 00: `alu_result`
  - 01: `alu_out`
  - 10: `{pc[31:28], IR[25:0], 2'b00}`
  - 11: `pc` (hold)
- PC load condition: `pc_load = PC_write | (Branch & alu_zero)`. On `pc_load`, `pc <= next` and `retired <= retired + 1` (16-bit wrap 16'hFFFF→0).
- `PC_write` and `Branch` asserted together: a single load, a single increment.
- `Pc_src_mux`=11 with `pc_load`: PC unchanged, `retired` still increments.
- Jump target uses the current IR, not `imem_rdata`.
- Simultaneous `IR_write` and `pc_load`: IR captures the word at the old PC, and PC updates. Both take effect at the same edge.
- No alignment check: `pc[1:0]` is stored as loaded, and `imem_addr` ignores it.

## Timing
- All registers update on the `clock` rising edge. Reset is asynchronous on assertion.
- `IR_write` at edge N: `op`/`Funct`/fields are valid after edge N, so the FSM samples them at edge N+1.
- `PC_write` at edge N: `pc` and `imem_addr` change after N, and `imem_rdata` is valid for an `IR_write` at edge N+1.
- Branch: `ALU_reg_write`=1 with target on `alu_result` at edge N captures the target. The compare cycle (`Branch`=1, `Pc_src_mux`=01, `alu_zero`=1) at edge M loads PC.
- Reset released mid-sequence: all state returns to reset values. There is no partial-update carryover.

## Structure
- Shared package `mips_pkg`:
  - opcodes ADDI 6'b001000, RTYPE 6'b000000, ORI 6'b001101, BEQ 6'b000100, J 6'b000010
  - funct ADD 6'b100000
  - `Pc_src_mux` encodings PCSRC_ALU=2'b00, PCSRC_ALUOUT=2'b01, PCSRC_JUMP=2'b10, PCSRC_HOLD=2'b11
- One sub-module, `en_reg`: parameterised width and reset value, async active-low reset, load enable. Instantiated for PC, IR and ALUOut.

## Test plan
- Reset: hold `rst`=0 with random inputs, then release. Required: `pc`=0, `op`=0, `Funct`=0, `alu_out`=0, `instr_valid`=0, `retired`=0.
- Fetch: `imem_rdata`=32'h2008_0005, pulse `IR_write`. Required: `op`=6'b001000, `rs`=0, `rt`=8, `imm_sext`=5, `instr_valid`=1.
- Sequential PC: `alu_result`=32'h4, `Pc_src_mux`=00, pulse `PC_write`. Required: `pc`=4, `imem_addr`=1, `retired`=1.
- BEQ:
  - Capture `alu_result`=32'h20 with `ALU_reg_write`=1, then drop `ALU_reg_write`.
  - Drive `Branch`=1, `Pc_src_mux`=01, `alu_zero`=0 → `pc` unchanged.
  - Repeat with `alu_zero`=1 → `pc`=32'h20.
- Jump: `pc`=32'h1000_0000, IR=32'h0800_0010, `Pc_src_mux`=10, pulse `PC_write`. Required: `pc`=32'h1000_0040.
- Edges:
  - `PC_write` and `Branch` with `alu_zero`=1 together → `retired` +1 only.
  - Preload `retired`=16'hFFFF, then one PC load → 0.
  - Assert `rst` mid-branch sequence → all outputs return to reset values immediately.
